// File: rtl/or_nway_pkg.sv
// Shared types and sizing helpers for the serial OR-reduction unit.
package or_nway_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/or_nway_serial_if.sv
// Word/result handshake bundle for or_nway_serial.
// first_idx exists only when OR_NWAY_FIRST_IDX_EN is defined.
interface or_nway_serial_if import or_nway_pkg::*; #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = idx_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out;
`ifdef OR_NWAY_FIRST_IDX_EN
  logic [IDX_W-1:0] first_idx;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out, first_idx);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out, first_idx);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out);
`endif
endinterface

// File: rtl/or_nway_chunk.sv
// Combinational CHUNK-wide OR plus lowest-set-bit encoder.
// The encoder is built only with OR_NWAY_FIRST_IDX_EN.
module or_nway_chunk import or_nway_pkg::*; #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0]             data,
`ifdef OR_NWAY_FIRST_IDX_EN
  output logic [idx_w(CHUNK)-1:0]      lsb_idx,
`endif
  output logic                         any
);

  assign any = |data;

`ifdef OR_NWAY_FIRST_IDX_EN
  localparam int LSB_W = idx_w(CHUNK);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    lsb_idx = '0;
    for (int i = CHUNK - 1; i >= 0; i--)
      if (data[i]) lsb_idx = LSB_W'(i);
  end
`endif

endmodule

// File: rtl/or_nway_serial.sv
// Multi-cycle OR-reduction: WIDTH-bit word reduced CHUNK bits per clock.
// Optional lowest-set-bit index behind OR_NWAY_FIRST_IDX_EN.
module or_nway_serial import or_nway_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              reset_n,
  or_nway_serial_if.slave  bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = idx_w(NCHUNK);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic [CNT_W-1:0] count;
  logic             last;
  logic             chunk_any;

  assign last = (count == CNT_W'(NCHUNK - 1));

`ifdef OR_NWAY_FIRST_IDX_EN
  localparam int IDX_W = idx_w(WIDTH);
  localparam int LSB_W = idx_w(CHUNK);

  logic [LSB_W-1:0] chunk_lsb;
  logic [IDX_W-1:0] fidx;
  logic             found;
`endif

  or_nway_chunk #(.CHUNK(CHUNK)) u_chunk (
    .data    (shreg[CHUNK-1:0]),
`ifdef OR_NWAY_FIRST_IDX_EN
    .lsb_idx (chunk_lsb),
`endif
    .any     (chunk_any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SCAN;
      SCAN:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath only moves in IDLE (capture) and SCAN; DONE holds everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg <= '0;
      acc   <= 1'b0;
      count <= '0;
`ifdef OR_NWAY_FIRST_IDX_EN
      fidx  <= '0;
      found <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          shreg <= bus.in_data;
          acc   <= 1'b0;
          count <= '0;
`ifdef OR_NWAY_FIRST_IDX_EN
          fidx  <= '0;
          found <= 1'b0;
`endif
        end
        SCAN: begin
          acc   <= acc | chunk_any;
          shreg <= shreg >> CHUNK;
          count <= count + 1'b1;
`ifdef OR_NWAY_FIRST_IDX_EN
          if (chunk_any && !found) begin
            fidx  <= IDX_W'(int'(count) * CHUNK + int'(chunk_lsb));
            found <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = acc;
`ifdef OR_NWAY_FIRST_IDX_EN
  assign bus.first_idx = fidx;
`endif

endmodule

// File: tb/tb_or_nway_serial.sv
// Self-checking bench for or_nway_serial (WIDTH=16, CHUNK=4): vector table,
// hand-written corner sequences and randomized words against a bit-level model.
module tb_or_nway_serial;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   accept_cyc;

  or_nway_serial_if #(.WIDTH(WIDTH)) bus ();

  or_nway_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        exp_out;
    logic [3:0]  exp_idx;
    int          hold;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idx(input string nm, input logic [3:0] exp);
`ifdef OR_NWAY_FIRST_IDX_EN
    chk(nm, 32'(bus.first_idx), 32'(exp));
`endif
  endtask

  // Reference model: OR of all bits and position of the lowest set bit.
  function automatic logic model_out(input logic [15:0] d);
    return d != 16'h0;
  endfunction

  function automatic logic [3:0] model_idx(input logic [15:0] d);
    for (int i = 0; i < WIDTH; i++)
      if (d[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word, measure latency, check the result, then release it.
  task automatic send(input logic [15:0] d, input logic eo, input logic [3:0] ei,
                      input int hold, input string nm);
    int t;
    logic rdy_seen;
    t = 0;
    while (!bus.in_ready && t < 50) begin tick(); t++; end
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    @(posedge clk);
    accept_cyc = cyc;
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hffff;
    t = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && t < 50) begin
      rdy_seen |= bus.in_ready;
      tick();
      t++;
    end
    chk({nm, "_latency"}, 32'(t), 32'(NCHUNK));
    chk({nm, "_scan_in_ready"}, 32'(rdy_seen), 32'd0);
    chk({nm, "_out"}, 32'(bus.out), 32'(eo));
    chk_idx({nm, "_idx"}, ei);
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    chk({nm, "_back_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  vec_t vecs[$];
  int   a0;
  logic [15:0] rd;

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk_idx("rst_idx", 4'd0);
    tick();

    vecs.push_back('{16'h0001, 1'b1, 4'd0,  0});
    vecs.push_back('{16'h0000, 1'b0, 4'd0,  0});
    vecs.push_back('{16'h0020, 1'b1, 4'd5,  0});
    vecs.push_back('{16'h1054, 1'b1, 4'd2,  0});
    vecs.push_back('{16'h8000, 1'b1, 4'd15, 0});
    vecs.push_back('{16'h0100, 1'b1, 4'd8,  2});
    vecs.push_back('{16'hF0F0, 1'b1, 4'd4,  0});
    foreach (vecs[i])
      send(vecs[i].data, vecs[i].exp_out, vecs[i].exp_idx, vecs[i].hold,
           $sformatf("vec%0d", i));

    // Back-to-back words: second accepted NCHUNK+2 cycles after the first.
    send(16'h1054, 1'b1, 4'd2, 0, "b2b_a");
    a0 = accept_cyc;
    send(16'h1055, 1'b1, 4'd0, 0, "b2b_b");
    chk("b2b_interval", 32'(accept_cyc - a0), 32'(NCHUNK + 2));

    // in_valid pulsed mid-SCAN must be ignored; 0x8000 resolves only on the last chunk.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h8000;
    tick();
    bus.in_data = 16'h0001;
    tick();
    chk("ign_rdy1", 32'(bus.in_ready), 32'd0);
    tick();
    chk("ign_rdy2", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("ign_rdy3", 32'(bus.in_ready), 32'd0);
    chk_idx("ign_idx_pending", 4'd0);
    chk("ign_not_done", 32'(bus.out_valid), 32'd0);
    tick();
    chk("ign_done", 32'(bus.out_valid), 32'd1);
    chk("ign_out", 32'(bus.out), 32'd1);
    chk_idx("ign_idx", 4'd15);
    tick();

    // Backpressure: result held stable for 5 cycles, then released.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1055;
    tick();
    bus.in_valid = 1'b0;
    repeat (NCHUNK) tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_out%0d", k), 32'(bus.out), 32'd1);
      chk_idx($sformatf("bp_idx%0d", k), 4'd0);
      chk($sformatf("bp_rdy%0d", k), 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);

    // Reset at the 2nd SCAN cycle discards the word.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out", 32'(bus.out), 32'd0);
    chk_idx("mrst_idx", 4'd0);
    send(16'h0100, 1'b1, 4'd8, 0, "mrst_next");

    // Randomized words with mixed density and random result backpressure.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       rd = 16'h0;
        1:       rd = 16'h1 << $urandom_range(0, 15);
        2:       rd = 16'($urandom & $urandom & $urandom);
        default: rd = 16'($urandom);
      endcase
      send(rd, model_out(rd), model_idx(rd), int'($urandom_range(0, 3)),
           $sformatf("rnd%0d_%04h", n, rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
